// File: rtl/alu_pkg.sv
// Shared ALU constants, opcode encoding and a reference model of the wrapper ALU.
// The request driver itself never decodes opcodes; alu_ref is for modelling only.
package alu_pkg;

    localparam int unsigned DW  = 4;
    localparam int unsigned OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

    // Returns {carry, result}; SUB carry is the borrow, shifts carry out the shifted-off bit.
    function automatic logic [DW:0] alu_ref(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [OPW-1:0] op);
        logic [DW:0] r;
        r = {1'b0, a};
        case (alu_op_e'(op))
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {a, 1'b0};
            OP_SHR:  r = {a[0], 1'b0, a[DW-1:1]};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with asynchronous reset; depth need not be a power of two.
module alu_rsp_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_req_driver.sv
// Initiator for the registered ALU wrapper: issues tagged requests, tracks in-flight ops
// and returns results in order through a credit-protected response FIFO.
module alu_req_driver
    import alu_pkg::*;
#(
    parameter int unsigned DW        = alu_pkg::DW,
    parameter int unsigned OPW       = alu_pkg::OPW,
    parameter int unsigned TAGW      = 2,
    parameter int unsigned LAT       = 2,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DW-1:0]   req_a,
    input  logic [DW-1:0]   req_b,
    input  logic [OPW-1:0]  req_op,
    input  logic [TAGW-1:0] req_tag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_result,
    output logic            rsp_carry,
    output logic [TAGW-1:0] rsp_tag,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [DW-1:0]   alu_result,
    input  logic            alu_carry,
    output logic            busy
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned FW = DW + 1 + TAGW;

    logic [LAT:0]      sr;
    logic [TAGW-1:0]   tg [LAT+1];
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_dout;

    // Credit covers both buffered and in-flight ops, so a capture always has room.
    assign req_ready = (cnt < CW'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;
    assign push      = sr[LAT];
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            sr     <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i <= LAT; i++) tg[i] <= '0;
        end else begin
            if (accept) begin
                alu_a  <= req_a;
                alu_b  <= req_b;
                alu_op <= req_op;
                tg[0]  <= req_tag;
            end
            sr <= {sr[LAT-1:0], accept};
            for (int unsigned i = 1; i <= LAT; i++) tg[i] <= tg[i-1];
            case ({accept, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    alu_rsp_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({alu_result, alu_carry, tg[LAT]}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign rsp_result = fifo_dout[FW-1 -: DW];
    assign rsp_carry  = fifo_dout[TAGW];
    assign rsp_tag    = fifo_dout[TAGW-1:0];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full);

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed and random bench for alu_req_driver with a behavioural 2-stage ALU wrapper.
module tb_alu_req_driver;
    import alu_pkg::*;

    localparam int TAGW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_a;
    logic [3:0]      req_b;
    logic [2:0]      req_op;
    logic [TAGW-1:0] req_tag;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [3:0]      rsp_result;
    logic            rsp_carry;
    logic [TAGW-1:0] rsp_tag;
    logic [3:0]      alu_a;
    logic [3:0]      alu_b;
    logic [2:0]      alu_op;
    logic [3:0]      alu_result;
    logic            alu_carry;
    logic            busy;

    int tests   = 0;
    int fails   = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [6:0] exp_q [$];
    logic       stall_d = 1'b0;
    logic [6:0] rsp_d   = '0;

    always #5 clk = ~clk;

    alu_req_driver #(
        .DW        (4),
        .OPW       (3),
        .TAGW      (TAGW),
        .LAT       (2),
        .RSP_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_tag    (rsp_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy)
    );

    // Wrapper model: input register then result register, sharing rst_n.
    logic [3:0] w_a, w_b;
    logic [2:0] w_op;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_a <= '0; w_b <= '0; w_op <= '0;
            alu_result <= '0; alu_carry <= 1'b0;
        end else begin
            w_a <= alu_a; w_b <= alu_b; w_op <= alu_op;
            {alu_carry, alu_result} <= alu_ref(w_a, w_b, w_op);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepts, check pops in order and stability while stalled.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_d = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                exp_q.push_back({alu_ref(req_a, req_b, req_op), req_tag});
                acc_cnt++;
            end
            if (stall_d)
                check("rsp_stable", {rsp_carry, rsp_result, rsp_tag}, rsp_d);
            if (rsp_valid && rsp_ready) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL rsp_unexpected: observed %0h expected no response",
                           {rsp_carry, rsp_result, rsp_tag});
                end
                if (exp_q.size() > 0) check("rsp_data", {rsp_carry, rsp_result, rsp_tag}, exp_q.pop_front());
                pop_cnt++;
            end
            stall_d = rsp_valid && !rsp_ready;
            rsp_d   = {rsp_carry, rsp_result, rsp_tag};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_acc, base_pop, g, elapsed;
        logic fire;

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();

        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_abop", {alu_a, alu_b, alu_op}, 0);
        rst_n = 1'b1;
        tick();

        // 1: single ADD 9+8 -> result 1, carry 1, visible 3 cycles after accept
        req_valid = 1'b1; req_a = 4'h9; req_b = 4'h8; req_op = OP_ADD; req_tag = 2'd1;
        tick();
        req_valid = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_alu_a", alu_a, 4'h9);
        tick();
        check("t1_valid_t1", rsp_valid, 0);
        tick();
        check("t1_valid_t2", rsp_valid, 0);
        tick();
        check("t1_valid_t3", rsp_valid, 1);
        check("t1_result", rsp_result, 4'h1);
        check("t1_carry", rsp_carry, 1);
        check("t1_tag", rsp_tag, 2'd1);
        rsp_ready = 1'b1;
        tick();
        check("t1_drained", {rsp_valid, busy}, 2'b00);

        // 2: back-to-back 8 requests with rsp_ready high
        base_acc = acc_cnt; base_pop = pop_cnt; elapsed = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_a = 4'(i * 3 + 1); req_b = 4'(15 - i);
            req_op = 3'(i); req_tag = 2'(i);
            g = 0;
            while (!req_ready && g < 10) begin tick(); g++; elapsed++; end
            tick(); elapsed++;
        end
        req_valid = 1'b0;
        check("t2_accepted", acc_cnt - base_acc, 8);
        check("t2_cycles_le10", elapsed <= 10, 1);
        g = 0;
        while (busy && g < 20) begin tick(); g++; end
        check("t2_idle", busy, 0);
        check("t2_responses", pop_cnt - base_pop, 8);

        // 3: rsp_ready low while issuing -> exactly 4 accepted
        rsp_ready = 1'b0; base_acc = acc_cnt; base_pop = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_a = 4'(i + 2); req_b = 4'(i * 5); req_op = 3'(7 - i); req_tag = 2'(i);
            tick();
        end
        req_valid = 1'b0;
        check("t3_accepted", acc_cnt - base_acc, 4);
        check("t3_ready_low", req_ready, 0);
        check("t3_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        check("t3_ready_before_pop", req_ready, 0);
        tick();
        check("t3_ready_after_pop", req_ready, 1);
        g = 0;
        while (busy && g < 10) begin tick(); g++; end
        check("t3_responses", pop_cnt - base_pop, 4);

        // 4: simultaneous accept and pop with the credit at its limit
        rsp_ready = 1'b0; base_acc = acc_cnt; base_pop = pop_cnt;
        req_valid = 1'b1; req_a = 4'hC; req_b = 4'h5; req_op = OP_SUB; req_tag = 2'd2;
        repeat (8) tick();
        check("t4_full_ready", req_ready, 0);
        req_a = 4'h3; req_b = 4'hA; req_op = OP_XOR; req_tag = 2'd3;
        rsp_ready = 1'b1;
        tick();
        check("t4_pop_only", {acc_cnt - base_acc, pop_cnt - base_pop}, {32'd4, 32'd1});
        check("t4_ready_after_pop", req_ready, 1);
        tick();
        check("t4_acc_and_pop", {acc_cnt - base_acc, pop_cnt - base_pop}, {32'd5, 32'd2});
        check("t4_ready_held", req_ready, 1);
        rsp_ready = 1'b0; req_a = 4'hF; req_b = 4'h1; req_op = OP_ADD; req_tag = 2'd0;
        tick();
        req_valid = 1'b0;
        check("t4_ready_at_limit", req_ready, 0);
        rsp_ready = 1'b1;
        g = 0;
        while (busy && g < 15) begin tick(); g++; end
        check("t4_responses", pop_cnt - base_pop, 6);

        // 5: reset with 2 ops in flight and 2 buffered
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_a = 4'(i); req_b = 4'(i + 1); req_op = OP_OR; req_tag = 2'(i);
            tick();
        end
        req_valid = 1'b0;
        tick();
        check("t5_pre_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outputs", {rsp_valid, req_ready, busy}, 3'b010);
        check("t5_rst_alu", {alu_a, alu_b, alu_op}, 0);
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1; base_pop = pop_cnt;
        repeat (8) tick();
        check("t5_no_responses", pop_cnt - base_pop, 0);
        check("t5_ready", {req_ready, rsp_valid}, 2'b10);

        // 6: random valid/ready, 1000 ops
        base_acc = acc_cnt; base_pop = pop_cnt; g = 0; fire = 1'b0;
        req_valid = 1'b0;
        while ((acc_cnt - base_acc) < 1000 && g < 20000) begin
            if (!req_valid || fire) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_a = 4'($urandom); req_b = 4'($urandom);
                req_op = 3'($urandom); req_tag = 2'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            fire = req_valid && req_ready;
            tick(); g++;
        end
        req_valid = 1'b0;
        check("t6_accepted", acc_cnt - base_acc, 1000);
        rsp_ready = 1'b1;
        g = 0;
        while (busy && g < 30) begin tick(); g++; end
        check("t6_idle", busy, 0);
        check("t6_responses", pop_cnt - base_pop, 1000);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
